mem_xfer_fsm: RTL and testbench

MEM_XFER_FSM -- requirements
Module: mem_xfer_fsm

---
 rtl/mem_fsm_pkg.sv | 67 ++++++
 rtl/mem_xfer_fsm_if.sv | 38 +++
 rtl/mem_timeout_ctr.sv | 32 +++
 rtl/mem_xfer_fsm.sv | 135 +++++++++++++
 tb/tb_mem_xfer_fsm.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_fsm_pkg.sv
// Shared state encoding, op codes and strobe decoding for the register/memory
// transfer controller.
package mem_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L_ADDR,
    L_MEM,
    L_WB,
    S_ADDR,
    S_DATA,
    S_MEM,
    DONE
  } state_t;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef struct packed {
    logic mar_write;
    logic mar_mem_read;
    logic mem_en;
    logic mem_rw;
    logic mdr_mem_write;
    logic mdr_read;
    logic mdr_write;
    logic mdr_mem_read;
    logic busy;
    logic done;
    logic err;
  } strobe_t;

  // Selects are zero-extended to 32 bits, so a register file wider than 32 is not supported.
  function automatic logic is_onehot(input logic [31:0] sel);
    return (sel != 32'd0) && ((sel & (sel - 32'd1)) == 32'd0);
  endfunction

  function automatic strobe_t strobes_for(input state_t s, input logic err);
    strobe_t st;
    st        = '0;
    st.mem_rw = 1'b1;
    st.busy   = (s != IDLE);
    case (s)
      L_ADDR, S_ADDR: st.mar_write = 1'b1;
      L_MEM: begin
        st.mar_mem_read  = 1'b1;
        st.mem_en        = 1'b1;
        st.mdr_mem_write = 1'b1;
      end
      L_WB:   st.mdr_read  = 1'b1;
      S_DATA: st.mdr_write = 1'b1;
      S_MEM: begin
        st.mar_mem_read = 1'b1;
        st.mdr_mem_read = 1'b1;
        st.mem_en       = 1'b1;
        st.mem_rw       = 1'b0;
      end
      DONE: begin
        st.done = 1'b1;
        st.err  = err;
      end
      default: ;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mem_xfer_fsm_if.sv
// Request, memory handshake and datapath strobe bundle of the transfer controller.
interface mem_xfer_fsm_if #(
  parameter int NREG = 5
);

  logic            start;
  logic            op;
  logic            MFC;
  logic [NREG-1:0] Ri;
  logic [NREG-1:0] Rj;

  logic [NREG-1:0] reg_read;
  logic [NREG-1:0] reg_write;
  logic            MAR_write;
  logic            MAR_mem_read;
  logic            MEM_EN;
  logic            MEM_RW;
  logic            MDR_mem_write;
  logic            MDR_read;
  logic            MDR_write;
  logic            MDR_mem_read;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output start, op, MFC, Ri, Rj,
    input  reg_read, reg_write, MAR_write, MAR_mem_read, MEM_EN, MEM_RW,
           MDR_mem_write, MDR_read, MDR_write, MDR_mem_read, busy, done, err
  );

  modport slave (
    input  start, op, MFC, Ri, Rj,
    output reg_read, reg_write, MAR_write, MAR_mem_read, MEM_EN, MEM_RW,
           MDR_mem_write, MDR_read, MDR_write, MDR_mem_read, busy, done, err
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Saturating wait counter for the memory phase; expired marks the last allowed cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [W-1:0] LAST = W'(LAST_I);
  localparam logic [W-1:0] MAX  = W'(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

  // TIMEOUT of zero leaves the memory phase waiting indefinitely.
  assign expired = (TIMEOUT > 0) && enable && (count >= LAST);

endmodule

// File: rtl/mem_xfer_fsm.sv
// Load/store sequencer that drives register, MAR and MDR strobes around a
// memory access completed by an active-low MFC.
module mem_xfer_fsm #(
  parameter int NREG    = 5,
  parameter int TIMEOUT = 16
) (
  input logic           clk,
  input logic           reset,
  mem_xfer_fsm_if.slave bus
);

  import mem_fsm_pkg::*;

  typedef struct packed {
    logic [NREG-1:0] rd;
    logic [NREG-1:0] wr;
    strobe_t         st;
  } drive_t;

  state_t          state;
  logic            op_q;
  logic [NREG-1:0] ri_q;
  logic [NREG-1:0] rj_q;
  drive_t          drv;
  logic            in_mem;
  logic            expired;

  function automatic drive_t drive_for(input state_t s, input logic [NREG-1:0] ri,
                                       input logic [NREG-1:0] rj, input logic err);
    drive_t d;
    d.st = strobes_for(s, err);
    d.rd = '0;
    d.wr = '0;
    case (s)
      L_ADDR, S_DATA: d.rd = rj;
      S_ADDR:         d.rd = ri;
      L_WB:           d.wr = ri;
      default: ;
    endcase
    return d;
  endfunction

  assign in_mem = (state == L_MEM) || (state == S_MEM);

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_mem),
    .enable (in_mem),
    .expired(expired)
  );

  // Outputs are registered: every transition loads the strobes of the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op_q  <= OP_LOAD;
      ri_q  <= '0;
      rj_q  <= '0;
      drv   <= drive_for(IDLE, '0, '0, 1'b0);
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q <= bus.op;
            ri_q <= bus.Ri;
            rj_q <= bus.Rj;
            if (!is_onehot(32'(bus.Ri)) || !is_onehot(32'(bus.Rj))) begin
              state <= DONE;
              drv   <= drive_for(DONE, '0, '0, 1'b1);
            end else if (bus.op == OP_STORE) begin
              state <= S_ADDR;
              drv   <= drive_for(S_ADDR, bus.Ri, bus.Rj, 1'b0);
            end else begin
              state <= L_ADDR;
              drv   <= drive_for(L_ADDR, bus.Ri, bus.Rj, 1'b0);
            end
          end
        end
        L_ADDR: begin
          state <= L_MEM;
          drv   <= drive_for(L_MEM, ri_q, rj_q, 1'b0);
        end
        S_ADDR: begin
          state <= S_DATA;
          drv   <= drive_for(S_DATA, ri_q, rj_q, 1'b0);
        end
        S_DATA: begin
          state <= S_MEM;
          drv   <= drive_for(S_MEM, ri_q, rj_q, 1'b0);
        end
        // A completion on the same cycle as expiry still counts as success.
        L_MEM, S_MEM: begin
          if (!bus.MFC) begin
            if (op_q == OP_STORE) begin
              state <= DONE;
              drv   <= drive_for(DONE, ri_q, rj_q, 1'b0);
            end else begin
              state <= L_WB;
              drv   <= drive_for(L_WB, ri_q, rj_q, 1'b0);
            end
          end else if (expired) begin
            state <= DONE;
            drv   <= drive_for(DONE, ri_q, rj_q, 1'b1);
          end
        end
        L_WB: begin
          state <= DONE;
          drv   <= drive_for(DONE, ri_q, rj_q, 1'b0);
        end
        default: begin
          state <= IDLE;
          drv   <= drive_for(IDLE, ri_q, rj_q, 1'b0);
        end
      endcase
    end
  end

  assign bus.reg_read      = drv.rd;
  assign bus.reg_write     = drv.wr;
  assign bus.MAR_write     = drv.st.mar_write;
  assign bus.MAR_mem_read  = drv.st.mar_mem_read;
  assign bus.MEM_EN        = drv.st.mem_en;
  assign bus.MEM_RW        = drv.st.mem_rw;
  assign bus.MDR_mem_write = drv.st.mdr_mem_write;
  assign bus.MDR_read      = drv.st.mdr_read;
  assign bus.MDR_write     = drv.st.mdr_write;
  assign bus.MDR_mem_read  = drv.st.mdr_mem_read;
  assign bus.busy          = drv.st.busy;
  assign bus.done          = drv.st.done;
  assign bus.err           = drv.st.err;

endmodule

// File: tb/tb_mem_xfer_fsm.sv
// Directed bench for mem_xfer_fsm: load, store, timeout, bad selects,
// ignored mid-transfer inputs and reset abort.
module tb_mem_xfer_fsm;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  mem_xfer_fsm_if #(.NREG(5)) bus ();

  mem_xfer_fsm #(
    .NREG   (5),
    .TIMEOUT(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic o, input logic [4:0] ri,
                               input logic [4:0] rj, input logic mfc);
    bus.start = s;
    bus.op    = o;
    bus.Ri    = ri;
    bus.Rj    = rj;
    bus.MFC   = mfc;
  endtask

  // Advance past the next rising edge so registered outputs have settled.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_memrw"}, 32'(bus.MEM_RW), 32'd1);
    checkOutput({tag, "_memen"}, 32'(bus.MEM_EN), 32'd0);
    checkOutput({tag, "_regs"}, 32'({bus.reg_read, bus.reg_write}), 32'd0);
    checkOutput({tag, "_strobes"}, 32'({bus.MAR_write, bus.MAR_mem_read, bus.MDR_mem_write,
                                        bus.MDR_read, bus.MDR_write, bus.MDR_mem_read, bus.err}), 32'd0);
  endtask

  initial begin
    int memCycles;
    logic sawWrite;
    logic sawDone;
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'b0, 5'b0, 1'b1);

    #12;
    checkIdleOutputs("reset");
    @(negedge clk);
    reset = 1'b1;
    nextCycle();
    checkIdleOutputs("idle");

    // Load with MFC low on the second L_MEM cycle
    applyStimulus(1'b1, 1'b0, 5'b00001, 5'b00100, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 5'b00001, 5'b00100, 1'b1);
    checkOutput("ld_addr_rd", 32'(bus.reg_read), 32'b00100);
    checkOutput("ld_addr_mar", 32'(bus.MAR_write), 32'd1);
    checkOutput("ld_addr_busy", 32'(bus.busy), 32'd1);
    checkOutput("ld_addr_memen", 32'(bus.MEM_EN), 32'd0);
    nextCycle();
    checkOutput("ld_mem1", 32'({bus.MEM_EN, bus.MEM_RW, bus.MAR_mem_read, bus.MDR_mem_write}), 32'hF);
    checkOutput("ld_mem1_rd", 32'({bus.reg_read, bus.MAR_write}), 32'd0);
    nextCycle();
    checkOutput("ld_mem2", 32'({bus.MEM_EN, bus.MEM_RW, bus.MAR_mem_read, bus.MDR_mem_write}), 32'hF);
    bus.MFC = 1'b0;
    nextCycle();
    bus.MFC = 1'b1;
    checkOutput("ld_wb_wr", 32'(bus.reg_write), 32'b00001);
    checkOutput("ld_wb_mdr", 32'(bus.MDR_read), 32'd1);
    checkOutput("ld_wb_memen", 32'(bus.MEM_EN), 32'd0);
    nextCycle();
    checkOutput("ld_done", 32'({bus.done, bus.err, bus.busy}), 32'b101);
    checkOutput("ld_done_wr", 32'(bus.reg_write), 32'd0);
    nextCycle();
    checkIdleOutputs("ld_after");

    // Store with MFC held low throughout; MFC is ignored before S_MEM
    applyStimulus(1'b1, 1'b1, 5'b00010, 5'b10000, 1'b0);
    nextCycle();
    bus.start = 1'b0;
    checkOutput("st_addr_rd", 32'(bus.reg_read), 32'b00010);
    checkOutput("st_addr_mar", 32'(bus.MAR_write), 32'd1);
    nextCycle();
    checkOutput("st_data_rd", 32'(bus.reg_read), 32'b10000);
    checkOutput("st_data_mdr", 32'({bus.MDR_write, bus.MAR_write, bus.MEM_EN}), 32'b100);
    nextCycle();
    checkOutput("st_mem", 32'({bus.MEM_EN, bus.MEM_RW, bus.MAR_mem_read, bus.MDR_mem_read, bus.MDR_mem_write}),
                32'b10110);
    checkOutput("st_mem_rd", 32'(bus.reg_read), 32'd0);
    nextCycle();
    checkOutput("st_done", 32'({bus.done, bus.err, bus.MEM_RW}), 32'b101);
    bus.MFC = 1'b1;
    nextCycle();
    checkIdleOutputs("st_after");

    // Load that never sees MFC: the memory phase is cut off after TIMEOUT cycles
    applyStimulus(1'b1, 1'b0, 5'b01000, 5'b00010, 1'b1);
    nextCycle();
    bus.start = 1'b0;
    nextCycle();
    memCycles = 0;
    sawWrite  = 1'b0;
    sawDone   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        sawDone = 1'b1;
        break;
      end
      if (bus.MEM_EN) memCycles++;
      if (bus.reg_write != 5'b0) sawWrite = 1'b1;
      nextCycle();
    end
    checkOutput("to_memcycles", 32'(memCycles), 32'd8);
    checkOutput("to_done_seen", 32'(sawDone), 32'd1);
    checkOutput("to_done_err", 32'({bus.done, bus.err}), 32'b11);
    checkOutput("to_no_wb", 32'(sawWrite), 32'd0);
    nextCycle();
    checkIdleOutputs("to_after");

    // Bad selects go straight to DONE with err and no strobes
    applyStimulus(1'b1, 1'b0, 5'b00011, 5'b00001, 1'b0);
    nextCycle();
    bus.start = 1'b0;
    checkOutput("bad_ri_done", 32'({bus.done, bus.err}), 32'b11);
    checkOutput("bad_ri_strobes", 32'({bus.MAR_write, bus.MEM_EN, bus.reg_read, bus.reg_write}), 32'd0);
    nextCycle();
    checkIdleOutputs("bad_ri_after");
    applyStimulus(1'b1, 1'b1, 5'b00001, 5'b00000, 1'b0);
    nextCycle();
    bus.start = 1'b0;
    checkOutput("bad_rj_done", 32'({bus.done, bus.err}), 32'b11);
    checkOutput("bad_rj_strobes", 32'({bus.MAR_write, bus.MEM_EN, bus.MDR_write, bus.reg_read}), 32'd0);
    nextCycle();

    // Select and op changes and a start pulse mid-transfer are ignored
    applyStimulus(1'b1, 1'b0, 5'b00100, 5'b00010, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 5'b10000, 5'b01000, 1'b1);
    checkOutput("mid_addr_rd", 32'(bus.reg_read), 32'b00010);
    nextCycle();
    bus.start = 1'b1;
    nextCycle();
    bus.start = 1'b0;
    checkOutput("mid_mem_hold", 32'({bus.MEM_EN, bus.MEM_RW, bus.busy}), 32'b111);
    bus.MFC = 1'b0;
    nextCycle();
    bus.MFC = 1'b1;
    checkOutput("mid_wb_wr", 32'(bus.reg_write), 32'b00100);
    nextCycle();
    checkOutput("mid_done", 32'({bus.done, bus.err}), 32'b10);
    nextCycle();
    checkIdleOutputs("mid_noqueue1");
    nextCycle();
    checkIdleOutputs("mid_noqueue2");

    // Reset during S_MEM aborts at once with no done pulse
    applyStimulus(1'b1, 1'b1, 5'b00001, 5'b00010, 1'b1);
    nextCycle();
    bus.start = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("rst_pre_smem", 32'({bus.MEM_EN, bus.MEM_RW}), 32'b10);
    #2;
    reset = 1'b0;
    #1;
    checkIdleOutputs("rst_abort");
    @(posedge clk);
    #3;
    reset = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      if (bus.done || bus.busy) sawDone = 1'b1;
    end
    checkOutput("rst_no_done", 32'(sawDone), 32'd0);

    // Fresh load after reset release with MFC already low
    applyStimulus(1'b1, 1'b0, 5'b10000, 5'b01000, 1'b0);
    nextCycle();
    bus.start = 1'b0;
    checkOutput("post_addr_rd", 32'(bus.reg_read), 32'b01000);
    nextCycle();
    checkOutput("post_mem", 32'(bus.MEM_EN), 32'd1);
    nextCycle();
    checkOutput("post_wb_wr", 32'(bus.reg_write), 32'b10000);
    nextCycle();
    checkOutput("post_done", 32'({bus.done, bus.err}), 32'b10);
    nextCycle();
    checkIdleOutputs("post_after");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
